min_index_writer: RTL and testbench
===================================

Name: min_index_writer

Overview:
- Downstream stage of the compress controller. Consumes the 8 Manhattan distances produced by the MAN0..7 units for each input vector and selects the nearest codebook entry (argmin).
- Writes the selected 3-bit index to RAM2.
- Re-times the controller's RAM2 write-enable, address and state so they stay aligned with the index. Feeds them back to the controller, which drives RAM2_WE, RAM2_A and done.

Parameters:
- DIST_W, 16, width of each distance input (unsigned).
- N_VEC, 4096, number of index writes expected per image.
- LAT, 3, pipeline latency in cycles. Fixed by the 3-level compare tree; not user-adjustable. Documented for the bench.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- data_en  in  1  distances valid this cycle (wr_ans phase)
- dist0..dist7  in  DIST_W each  distance of codebook entry 0..7, aligned with data_en
- RAM2_WE_reg_in  in  1  write enable from controller, aligned with data_en
- RAM2_A_reg_in  in  20  RAM2 address from controller, aligned with data_en
- state_in  in  2  controller state: 0 idle, 1 wr_weight, 2 wr_ans, 3 have_done
- RAM2_WE_reg_out  out  1  delayed write enable, back to controller
- RAM2_A_reg_out  out  20  delayed address, back to controller
- RAM2_D  out  24  {21'b0, index}
- state_out  out  2  delayed/qualified state, back to controller state_in
- wr_count  out  13  index writes issued since reset
- err  out  1  sticky: more than N_VEC writes, or WE without data_en

Behaviour:
- Reset values: all outputs 0. All pipeline valid bits 0. Internal FSM in S_IDLE. Reset mid-image aborts immediately; no partial write is emitted after rst deasserts.
- Stage 1 (register): 4 pairwise compares (0,1), (2,3), (4,5), (6,7). Keep min value and index.
- Stage 2 (register): 2 compares.
- Stage 3 (register): final compare. Drive RAM2_D, RAM2_WE_reg_out and RAM2_A_reg_out.
- Latency is exactly 3 cycles from data_en / RAM2_WE_reg_in / RAM2_A_reg_in to the outputs. One result per cycle, no stalls, no backpressure.
- Comparison: unsigned, full DIST_W width.
- Tie-break: strictly-less replaces, so the lowest index wins on equal distances.
- WE/A pass through a 3-deep shift register in parallel with the tree. The address is not modified.
- RAM2_WE_reg_out is 1 only when the delayed WE and the delayed data_en are both 1.
- WE=1 with data_en=0 drops the write and sets err.
- The RAM2_D value is held when WE is 0.
- wr_count increments on each RAM2_WE_reg_out=1 and saturates at 8191.
- A write when wr_count is already N_VEC sets err. The write is still issued.
- FSM governs state_out. Transitions:
  - S_IDLE: state_out=0. When state_in≠0, go to S_PASS.
  - S_PASS: state_out = state_in delayed by 3 cycles, but a delayed value of 3 is replaced by 2. When delayed state_in==3, go to S_DRAIN.
  - S_DRAIN: state_out=2. When all 3 pipeline valid bits are 0, go to S_DONE.
  - S_DONE: state_out=3, held until rst.
- Consequence: done asserts no earlier than the cycle after the last RAM2 write.
- data_en asserted while in S_DONE is ignored; no write and no count.
- Simultaneous final write and state_in==3: the write completes and is counted, then DONE follows.

Decomposition:
- Shared package compress_pkg holds:
  - state codes ST_IDLE=0, ST_WR_WEIGHT=1, ST_WR_ANS=2, ST_DONE=3 (shared with the controller);
  - RAM address width 20 and data width 24;
  - the N_VEC default.
- One natural sub-module, min2_sel: 2-input unsigned compare with index passthrough and lowest-index tie-break. Instantiated 7 times (4+2+1).

Test Plan:
- Reset: rst=1 mid-stream with the pipeline full → all outputs 0 next cycle; no write after release until new data_en.
- Single vector: dist={50,40,30,20,10,60,70,80}, data_en=1, WE=1, A=0x00005 at cycle t → at t+3 WE_out=1, A_out=0x00005, RAM2_D=4.
- Ties: all dist=100 → RAM2_D=0. dist5=dist6=7, others 9 → RAM2_D=5. Extremes: all 0xFFFF except dist7=0xFFFE → 7.
- Streaming: 4096 back-to-back vectors with random distances checked against a reference argmin. A runs 0..4095, one write per cycle, wr_count=4096, err=0.
- Done ordering: state_in goes 2→3 on the cycle of the last data_en → state_out stays 2 for 3 cycles, becomes 3 at t+4 after the final write. data_en pulses afterwards produce no write.
- Errors: WE=1 with data_en=0 → no write, err=1. A 4097th write → issued, wr_count=4097, err=1.

Source files
------------

// File: rtl/compress_pkg.sv
// Shared definitions for the compress controller and its downstream stages.
// Controller state codes, RAM geometry and the per-image write count.
package compress_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WR_WEIGHT = 2'd1,
    ST_WR_ANS    = 2'd2,
    ST_DONE      = 2'd3
  } ctrl_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS,
    S_DRAIN,
    S_DONE
  } miw_state_e;

  localparam int unsigned RAM_AW    = 20;
  localparam int unsigned RAM_DW    = 24;
  localparam int unsigned N_VEC_DEF = 4096;
  localparam int unsigned CNT_W     = 13;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned LAT       = 3;

endpackage

// File: rtl/min_index_writer_if.sv
// Bundle between the compress controller (master) and min_index_writer (slave).
// Carries the distance vector, the controller's RAM2 write request and the fed-back results.
interface min_index_writer_if #(
  parameter int unsigned DIST_W = 16
);
  logic                                data_en;
  logic [DIST_W-1:0]                   dist0, dist1, dist2, dist3;
  logic [DIST_W-1:0]                   dist4, dist5, dist6, dist7;
  logic                                RAM2_WE_reg_in;
  logic [compress_pkg::RAM_AW-1:0]     RAM2_A_reg_in;
  logic [1:0]                          state_in;

  logic                                RAM2_WE_reg_out;
  logic [compress_pkg::RAM_AW-1:0]     RAM2_A_reg_out;
  logic [compress_pkg::RAM_DW-1:0]     RAM2_D;
  logic [1:0]                          state_out;
  logic [compress_pkg::CNT_W-1:0]      wr_count;
  logic                                err;

  modport master (
    output data_en, dist0, dist1, dist2, dist3, dist4, dist5, dist6, dist7,
    output RAM2_WE_reg_in, RAM2_A_reg_in, state_in,
    input  RAM2_WE_reg_out, RAM2_A_reg_out, RAM2_D, state_out, wr_count, err
  );

  modport slave (
    input  data_en, dist0, dist1, dist2, dist3, dist4, dist5, dist6, dist7,
    input  RAM2_WE_reg_in, RAM2_A_reg_in, state_in,
    output RAM2_WE_reg_out, RAM2_A_reg_out, RAM2_D, state_out, wr_count, err
  );
endinterface

// File: rtl/min2_sel.sv
// Two-input unsigned minimum with index passthrough.
// The "a" operand must carry the lower index: b wins only when strictly smaller.
module min2_sel #(
  parameter int unsigned DIST_W = 16,
  parameter int unsigned IDX_W  = 3
) (
  input  logic [DIST_W-1:0] a_dist,
  input  logic [IDX_W-1:0]  a_idx,
  input  logic [DIST_W-1:0] b_dist,
  input  logic [IDX_W-1:0]  b_idx,
  output logic [DIST_W-1:0] min_dist,
  output logic [IDX_W-1:0]  min_idx
);
  logic take_b;

  assign take_b   = b_dist < a_dist;
  assign min_dist = take_b ? b_dist : a_dist;
  assign min_idx  = take_b ? b_idx : a_idx;
endmodule

// File: rtl/min_index_writer.sv
// Argmin over 8 distances through a 3-level registered compare tree, writing the index to RAM2
// with the controller's WE/address/state re-timed alongside it.
module min_index_writer
  import compress_pkg::*;
#(
  parameter int unsigned DIST_W = 16,
  parameter int unsigned N_VEC  = N_VEC_DEF
) (
  input logic               clk,
  input logic               rst,
  min_index_writer_if.slave bus
);
  miw_state_e fsm_q;

  logic              in_en, in_we, wr;
  logic [DIST_W-1:0] dist_in [8];

  logic [DIST_W-1:0] l1_dist_d [4];
  logic [DIST_W-1:0] l1_dist_q [4];
  logic [IDX_W-1:0]  l1_idx_d  [4];
  logic [IDX_W-1:0]  l1_idx_q  [4];
  logic [DIST_W-1:0] l2_dist_d [2];
  logic [DIST_W-1:0] l2_dist_q [2];
  logic [IDX_W-1:0]  l2_idx_d  [2];
  logic [IDX_W-1:0]  l2_idx_q  [2];
  logic [DIST_W-1:0] unused_l3_dist;
  logic [IDX_W-1:0]  l3_idx;

  logic              v1_q, v2_q, we1_q, we2_q;
  logic [RAM_AW-1:0] a1_q, a2_q;
  logic [1:0]        st1_q, st2_q;

  // Once done, the controller's requests are ignored entirely.
  assign in_en = bus.data_en & (fsm_q != S_DONE);
  assign in_we = bus.RAM2_WE_reg_in & (fsm_q != S_DONE);
  assign wr    = v2_q & we2_q;

  assign dist_in[0] = bus.dist0;
  assign dist_in[1] = bus.dist1;
  assign dist_in[2] = bus.dist2;
  assign dist_in[3] = bus.dist3;
  assign dist_in[4] = bus.dist4;
  assign dist_in[5] = bus.dist5;
  assign dist_in[6] = bus.dist6;
  assign dist_in[7] = bus.dist7;

  for (genvar g = 0; g < 4; g++) begin : g_l1
    min2_sel #(.DIST_W(DIST_W), .IDX_W(IDX_W)) u_min (
      .a_dist  (dist_in[2*g]),
      .a_idx   (IDX_W'(2*g)),
      .b_dist  (dist_in[2*g+1]),
      .b_idx   (IDX_W'(2*g+1)),
      .min_dist(l1_dist_d[g]),
      .min_idx (l1_idx_d[g])
    );
  end

  for (genvar g = 0; g < 2; g++) begin : g_l2
    min2_sel #(.DIST_W(DIST_W), .IDX_W(IDX_W)) u_min (
      .a_dist  (l1_dist_q[2*g]),
      .a_idx   (l1_idx_q[2*g]),
      .b_dist  (l1_dist_q[2*g+1]),
      .b_idx   (l1_idx_q[2*g+1]),
      .min_dist(l2_dist_d[g]),
      .min_idx (l2_idx_d[g])
    );
  end

  min2_sel #(.DIST_W(DIST_W), .IDX_W(IDX_W)) u_l3 (
    .a_dist  (l2_dist_q[0]),
    .a_idx   (l2_idx_q[0]),
    .b_dist  (l2_dist_q[1]),
    .b_idx   (l2_idx_q[1]),
    .min_dist(unused_l3_dist),
    .min_idx (l3_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        l1_dist_q[i] <= '0;
        l1_idx_q[i]  <= '0;
      end
      for (int i = 0; i < 2; i++) begin
        l2_dist_q[i] <= '0;
        l2_idx_q[i]  <= '0;
      end
      v1_q                <= 1'b0;
      v2_q                <= 1'b0;
      we1_q               <= 1'b0;
      we2_q               <= 1'b0;
      a1_q                <= '0;
      a2_q                <= '0;
      st1_q               <= '0;
      st2_q               <= '0;
      bus.RAM2_WE_reg_out <= 1'b0;
      bus.RAM2_A_reg_out  <= '0;
      bus.RAM2_D          <= '0;
      bus.wr_count        <= '0;
      bus.err             <= 1'b0;
    end else begin
      l1_dist_q           <= l1_dist_d;
      l1_idx_q            <= l1_idx_d;
      l2_dist_q           <= l2_dist_d;
      l2_idx_q            <= l2_idx_d;
      v1_q                <= in_en;
      v2_q                <= v1_q;
      we1_q               <= in_we;
      we2_q               <= we1_q;
      a1_q                <= bus.RAM2_A_reg_in;
      a2_q                <= a1_q;
      st1_q               <= bus.state_in;
      st2_q               <= st1_q;
      bus.RAM2_WE_reg_out <= wr;
      bus.RAM2_A_reg_out  <= a2_q;
      if (wr) begin
        bus.RAM2_D <= {{(RAM_DW-IDX_W){1'b0}}, l3_idx};
      end
      if (wr && bus.wr_count != '1) begin
        bus.wr_count <= bus.wr_count + 1'b1;
      end
      // Overrun still writes; it only flags the image as bad.
      if ((we2_q && !v2_q) || (wr && bus.wr_count == CNT_W'(N_VEC))) begin
        bus.err <= 1'b1;
      end
    end
  end

  // state_out shows state_in delayed to line up with RAM2 writes; done waits for an empty pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q         <= S_IDLE;
      bus.state_out <= ST_IDLE;
    end else begin
      unique case (fsm_q)
        S_IDLE: begin
          bus.state_out <= ST_IDLE;
          if (bus.state_in != ST_IDLE) fsm_q <= S_PASS;
        end
        S_PASS: begin
          if (st2_q == ST_DONE) begin
            bus.state_out <= ST_WR_ANS;
            fsm_q         <= S_DRAIN;
          end else begin
            bus.state_out <= st2_q;
          end
        end
        S_DRAIN: begin
          if (!(in_en || v1_q || v2_q)) begin
            bus.state_out <= ST_DONE;
            fsm_q         <= S_DONE;
          end else begin
            bus.state_out <= ST_WR_ANS;
          end
        end
        S_DONE: begin
          bus.state_out <= ST_DONE;
        end
        default: begin
          bus.state_out <= ST_IDLE;
          fsm_q         <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_min_index_writer.sv
// Directed bench for min_index_writer: reset, argmin/ties, streaming image, errors, done ordering.
module tb_min_index_writer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;
  logic [2:0] exp_idx [4096];

  min_index_writer_if #(.DIST_W(16)) bus ();

  min_index_writer #(.DIST_W(16), .N_VEC(4096)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_dist(input logic [15:0] d0, d1, d2, d3, d4, d5, d6, d7);
    bus.dist0 = d0; bus.dist1 = d1; bus.dist2 = d2; bus.dist3 = d3;
    bus.dist4 = d4; bus.dist5 = d5; bus.dist6 = d6; bus.dist7 = d7;
  endtask

  task automatic drive(input logic en, input logic we, input logic [19:0] a,
                       input logic [1:0] st);
    bus.data_en        = en;
    bus.RAM2_WE_reg_in = we;
    bus.RAM2_A_reg_in  = a;
    bus.state_in       = st;
  endtask

  // Drive one vector with the dists already set, then check it three cycles later.
  task automatic run_one(input string tag, input logic [19:0] a, input logic [2:0] idx);
    drive(1'b1, 1'b1, a, 2'd2);
    tick();
    drive(1'b0, 1'b0, 20'h0, 2'd2);
    tick();
    chk({tag, "_early_we"}, 32'(bus.RAM2_WE_reg_out), 32'd0);
    tick();
    chk({tag, "_we"}, 32'(bus.RAM2_WE_reg_out), 32'd1);
    chk({tag, "_addr"}, 32'(bus.RAM2_A_reg_out), 32'(a));
    chk({tag, "_data"}, 32'(bus.RAM2_D), 32'(idx));
  endtask

  initial begin
    logic [15:0] d [8];
    logic [15:0] best;
    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    set_dist(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    drive(1'b0, 1'b0, 20'h0, 2'd0);
    tick();
    tick();

    chk("rst_we", 32'(bus.RAM2_WE_reg_out), 32'd0);
    chk("rst_addr", 32'(bus.RAM2_A_reg_out), 32'd0);
    chk("rst_data", 32'(bus.RAM2_D), 32'd0);
    chk("rst_state", 32'(bus.state_out), 32'd0);
    chk("rst_count", 32'(bus.wr_count), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    tick();

    set_dist(16'd50, 16'd40, 16'd30, 16'd20, 16'd10, 16'd60, 16'd70, 16'd80);
    run_one("single", 20'h00005, 3'd4);
    chk("single_count", 32'(bus.wr_count), 32'd1);
    tick();
    chk("hold_we", 32'(bus.RAM2_WE_reg_out), 32'd0);
    chk("hold_data", 32'(bus.RAM2_D), 32'd4);
    chk("pass_state", 32'(bus.state_out), 32'd2);

    set_dist(16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100);
    run_one("tie_all", 20'h00010, 3'd0);
    set_dist(16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd7, 16'd7, 16'd9);
    run_one("tie_56", 20'h00011, 3'd5);
    set_dist(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE);
    run_one("extreme", 20'hFFFFF, 3'd7);
    chk("ties_count", 32'(bus.wr_count), 32'd4);
    chk("ties_err", 32'(bus.err), 32'd0);

    // WE without data_en: dropped and flagged.
    drive(1'b0, 1'b1, 20'h00020, 2'd2);
    tick();
    drive(1'b0, 1'b0, 20'h0, 2'd2);
    tick();
    tick();
    chk("we_noen_we", 32'(bus.RAM2_WE_reg_out), 32'd0);
    chk("we_noen_err", 32'(bus.err), 32'd1);
    chk("we_noen_count", 32'(bus.wr_count), 32'd4);
    chk("we_noen_data", 32'(bus.RAM2_D), 32'd7);

    // Reset with the pipeline full.
    set_dist(16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd6, 16'd7, 16'd8);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 20'(i + 32), 2'd2);
      tick();
    end
    rst = 1'b1;
    drive(1'b0, 1'b0, 20'h0, 2'd2);
    tick();
    chk("midrst_we", 32'(bus.RAM2_WE_reg_out), 32'd0);
    chk("midrst_addr", 32'(bus.RAM2_A_reg_out), 32'd0);
    chk("midrst_data", 32'(bus.RAM2_D), 32'd0);
    chk("midrst_state", 32'(bus.state_out), 32'd0);
    chk("midrst_count", 32'(bus.wr_count), 32'd0);
    chk("midrst_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("postrst_we", 32'(bus.RAM2_WE_reg_out), 32'd0);
    end
    chk("postrst_count", 32'(bus.wr_count), 32'd0);

    // Full image, back to back.
    for (int i = 0; i < 4096 + 2; i++) begin
      if (i < 4096) begin
        best = 16'hFFFF;
        exp_idx[i] = 3'd0;
        for (int k = 0; k < 8; k++) begin
          d[k] = 16'($urandom_range(0, 65535));
          if (k == 0 || d[k] < best) begin
            best       = d[k];
            exp_idx[i] = 3'(k);
          end
        end
        set_dist(d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7]);
        drive(1'b1, 1'b1, 20'(i), 2'd2);
      end else begin
        drive(1'b0, 1'b0, 20'h0, 2'd2);
      end
      tick();
      if (i >= 2) begin
        chk("stream_we", 32'(bus.RAM2_WE_reg_out), 32'd1);
        chk("stream_addr", 32'(bus.RAM2_A_reg_out), 32'(i - 2));
        chk("stream_data", 32'(bus.RAM2_D), 32'(exp_idx[i - 2]));
      end
    end
    chk("stream_count", 32'(bus.wr_count), 32'd4096);
    chk("stream_err", 32'(bus.err), 32'd0);
    chk("stream_state", 32'(bus.state_out), 32'd2);

    // 4097th write together with state_in going to 3.
    set_dist(16'd9, 16'd8, 16'd7, 16'd1, 16'd9, 16'd9, 16'd9, 16'd9);
    drive(1'b1, 1'b1, 20'h01000, 2'd3);
    tick();
    drive(1'b0, 1'b0, 20'h0, 2'd3);
    chk("done_t1_state", 32'(bus.state_out), 32'd2);
    tick();
    chk("done_t2_state", 32'(bus.state_out), 32'd2);
    tick();
    chk("done_t3_state", 32'(bus.state_out), 32'd2);
    chk("over_we", 32'(bus.RAM2_WE_reg_out), 32'd1);
    chk("over_addr", 32'(bus.RAM2_A_reg_out), 32'h01000);
    chk("over_data", 32'(bus.RAM2_D), 32'd3);
    chk("over_count", 32'(bus.wr_count), 32'd4097);
    chk("over_err", 32'(bus.err), 32'd1);
    tick();
    chk("done_t4_state", 32'(bus.state_out), 32'd3);

    // Requests after done are ignored.
    drive(1'b1, 1'b1, 20'h00077, 2'd3);
    tick();
    drive(1'b0, 1'b0, 20'h0, 2'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("after_done_we", 32'(bus.RAM2_WE_reg_out), 32'd0);
    end
    chk("after_done_count", 32'(bus.wr_count), 32'd4097);
    chk("after_done_state", 32'(bus.state_out), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
